// File: rtl/ahb_slave_pkg.sv
// ----------------------------------------------------------------------------
// ahb_slave_pkg
//   Shared types and helpers for the AHB-lite SRAM slave.
//   - htrans_e / hresp_e / hsize_e : AHB-lite encodings
//   - slave_state_e               : data-phase FSM states of the slave
//   - RESP_OKAY / RESP_ERROR      : hresp constants
//   - max_hsize()                 : largest legal hsize for a data width
// ----------------------------------------------------------------------------
package ahb_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slave_state_e;

    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    // log2 of the bus width in bytes: 2 for a 32-bit bus, 3 for a 64-bit bus.
    function automatic logic [2:0] max_hsize(input int unsigned data_width);
        return (data_width == 64) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// ----------------------------------------------------------------------------
// ahb_byte_lane_decode
//   Purely combinational: turns (hsize, low address bits) into a little-endian
//   byte-strobe vector and a misalignment flag.
//   Ports:
//     hsize_i      : transfer size (0 byte .. 3 dword)
//     addr_lo_i    : byte offset inside the bus word
//     strb_o       : one bit per byte lane written/read by the transfer
//     misaligned_o : address not a multiple of the transfer size
//   Strobes are only meaningful when the access is aligned and the size is
//   legal for the bus width; the caller filters those cases as errors.
// ----------------------------------------------------------------------------
module ahb_byte_lane_decode
    import ahb_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NBYTES     = DATA_WIDTH / 8,
    parameter int LANE_BITS  = $clog2(NBYTES)
) (
    input  logic [2:0]           hsize_i,
    input  logic [LANE_BITS-1:0] addr_lo_i,
    output logic [NBYTES-1:0]    strb_o,
    output logic                 misaligned_o
);

    // Bits of the offset that lie inside one transfer of this size.
    logic [LANE_BITS-1:0] size_mask;

    always_comb begin
        size_mask = '0;
        strb_o    = '0;
        for (int k = 0; k < LANE_BITS; k++) begin
            size_mask[k] = (3'(k) < hsize_i);
        end
        misaligned_o = |(addr_lo_i & size_mask);
        // A lane is selected when it lies in the same size-aligned block as
        // the start address.
        for (int i = 0; i < NBYTES; i++) begin
            strb_o[i] = ((LANE_BITS'(i) & ~size_mask) == (addr_lo_i & ~size_mask));
        end
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_lite_sram_slave
//   AHB-lite slave backed by a DATA_WIDTH x MEM_DEPTH memory, with a fixed
//   number of wait states per OKAY data phase and the two-cycle ERROR
//   response for illegal accesses (bad size, misaligned, out of range).
//   Ports:
//     hclk, hresetn      : clock, asynchronous active-low reset
//     hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready_in
//                        : address-phase inputs (hburst/hprot are ignored)
//     hwdata             : write data, valid in the data phase
//     hreadyout, hresp   : data-phase handshake and response
//     hrdata             : read data, full bus word, zero outside DATA
//     dbg_state_o        : current FSM state, for observation only
//   Handshake: a transfer is accepted at a rising edge when
//   hsel & hready_in & htrans[1] & hreadyout; its data phase then runs until
//   an edge where hreadyout is high. A write commits at that final edge.
// ----------------------------------------------------------------------------
module ahb_lite_sram_slave
    import ahb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0,
    parameter int ERR_ON_OOR  = 1
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hready_in,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hreadyout,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic [1:0]            hresp,
    output slave_state_e          dbg_state_o
);

    localparam int         NBYTES    = DATA_WIDTH / 8;
    localparam int         LANE_BITS = $clog2(NBYTES);
    localparam int         IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE  = max_hsize(DATA_WIDTH);

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [LANE_BITS-1:0]  addr_lo;
    logic [NBYTES-1:0]     strb;
    logic                  misaligned;
    logic                  size_err;
    logic                  oor_err;
    logic                  illegal;

    assign addr_lo   = haddr[LANE_BITS-1:0];
    assign word_addr = haddr >> LANE_BITS;
    assign size_err  = (hsize > MAX_SIZE);
    assign oor_err   = (ERR_ON_OOR != 0) && (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
    assign illegal   = size_err | misaligned | oor_err;

    ahb_byte_lane_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_decode (
        .hsize_i      (hsize),
        .addr_lo_i    (addr_lo),
        .strb_o       (strb),
        .misaligned_o (misaligned)
    );

    // Burst type and protection do not change behaviour.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot};

    // ------------------------------------------------------------------
    // FSM and captured transfer
    // ------------------------------------------------------------------
    slave_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NBYTES-1:0] strb_q, strb_d;
    logic              write_q, write_d;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            strb_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            strb_q  <= strb_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        strb_d    = strb_q;
        write_d   = write_q;
        hreadyout = 1'b1;
        hresp     = RESP_OKAY;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DATA: begin
                state_d = ST_IDLE;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = RESP_ERROR;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new address phase is only taken while this slave is ready, so
        // IDLE, DATA and ERR2 all pipeline straight into the next transfer.
        if (hreadyout && hsel && hready_in && htrans[1]) begin
            idx_d   = word_addr[IDX_W-1:0];
            strb_d  = strb;
            write_d = hwrite;
            if (illegal) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    assign dbg_state_o = state_q;

    // ------------------------------------------------------------------
    // Memory array (not reset). Writes land at the edge ending DATA; a
    // reset that forces state_q to IDLE therefore drops the pending write.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge hclk) begin
        if (state_q == ST_DATA && write_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (strb_q[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

    assign hrdata = (state_q == ST_DATA) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
`timescale 1ns/1ps
module tb_ahb_lite_sram_slave;
    import ahb_slave_pkg::*;

    localparam int DEPTH = 256;

    function automatic int ws_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic bit oor_of(input int d);
        return (d != 2);
    endfunction

    // ------------------------------------------------------------------
    // Clock / reset and bus
    // ------------------------------------------------------------------
    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    logic        hsel_bus;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    int          cur = 0;

    logic         hsel0, hsel1, hsel2;
    logic         rdy0, rdy1, rdy2;
    logic [1:0]   resp0, resp1, resp2;
    logic [31:0]  rd0, rd1, rd2;
    slave_state_e st0, st1, st2;

    assign hsel0 = hsel_bus && (cur == 0);
    assign hsel1 = hsel_bus && (cur == 1);
    assign hsel2 = hsel_bus && (cur == 2);

    // u0: no wait states, range errors; u1: 3 wait states; u2: address wrap
    ahb_lite_sram_slave #(.WAIT_STATES(0), .ERR_ON_OOR(1)) u0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_in(rdy0),
        .hwdata(hwdata), .hreadyout(rdy0), .hrdata(rd0), .hresp(resp0), .dbg_state_o(st0));
    ahb_lite_sram_slave #(.WAIT_STATES(3), .ERR_ON_OOR(1)) u1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_in(rdy1),
        .hwdata(hwdata), .hreadyout(rdy1), .hrdata(rd1), .hresp(resp1), .dbg_state_o(st1));
    ahb_lite_sram_slave #(.WAIT_STATES(0), .ERR_ON_OOR(0)) u2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_in(rdy2),
        .hwdata(hwdata), .hreadyout(rdy2), .hrdata(rd2), .hresp(resp2), .dbg_state_o(st2));

    logic         o_rdy;
    logic [1:0]   o_resp;
    logic [31:0]  o_rdata;
    slave_state_e o_st;

    always_comb begin
        o_rdy = rdy0; o_resp = resp0; o_rdata = rd0; o_st = st0;
        case (cur)
            1: begin o_rdy = rdy1; o_resp = resp1; o_rdata = rd1; o_st = st1; end
            2: begin o_rdy = rdy2; o_resp = resp2; o_rdata = rd2; o_st = st2; end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", tag, cur, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-slave word array, rules computed from sizes
    // and byte addresses directly.
    // ------------------------------------------------------------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          gap;
    } xfer_t;

    xfer_t       xq[$];
    logic [31:0] mdl [3][DEPTH];
    logic [31:0] last_rd;

    function automatic bit mdl_err(input int d, input xfer_t x);
        int nbytes;
        nbytes = 1 << x.size;
        if (x.size > 3'd2) return 1'b1;
        if ((x.addr % nbytes) != 0) return 1'b1;
        if (oor_of(d) && ((x.addr / 4) >= DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mdl_idx(input xfer_t x);
        return (x.addr / 4) % DEPTH;
    endfunction

    task automatic mdl_write(input int d, input xfer_t x);
        int lane;
        for (int b = 0; b < (1 << x.size); b++) begin
            lane = (x.addr % 4) + b;
            mdl[d][mdl_idx(x)][lane*8 +: 8] = x.wdata[lane*8 +: 8];
        end
    endtask

    task automatic push(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int gap);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.gap = gap;
        xq.push_back(x);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic idle_drive();
        haddr  = $urandom;
        hwrite = 1'($urandom);
        hsize  = 3'($urandom_range(0, 2));
        hburst = 3'($urandom);
        hprot  = 4'($urandom);
        case ($urandom_range(0, 2))
            0:       begin hsel_bus = 1'b0; htrans = HTRANS_NONSEQ; end
            1:       begin hsel_bus = 1'b1; htrans = HTRANS_IDLE;   end
            default: begin hsel_bus = 1'b1; htrans = HTRANS_BUSY;   end
        endcase
    endtask

    // Checks one completed data phase against the model.
    task automatic complete(input xfer_t x, input int low, input bit bad_low,
                            input logic [1:0] resp, input logic [31:0] rdata);
        bit err;
        err = mdl_err(cur, x);
        check_eq("low_cycles", 32'(low), err ? 32'd1 : 32'(ws_of(cur)));
        check_eq("low_phase_outputs", {31'd0, bad_low}, 32'd0);
        check_eq("resp", {30'd0, resp}, err ? 32'd1 : 32'd0);
        if (err) begin
            check_eq("err_rdata", rdata, 32'd0);
        end else if (!x.wr) begin
            check_eq("rdata", rdata, mdl[cur][mdl_idx(x)]);
            last_rd = rdata;
        end else begin
            mdl_write(cur, x);
        end
    endtask

    // Pipelined master: drives queued transfers on slave `cur`, overlapping
    // each address phase with the previous data phase.
    task automatic run_seq();
        xfer_t       dp;
        bit          have_dp;
        bit          drive_addr;
        bit          bad_low;
        bit          exp_err;
        int          low;
        int          gap_left;
        logic        r_rdy;
        logic [1:0]  r_resp;
        logic [31:0] r_rd;
        have_dp  = 1'b0;
        bad_low  = 1'b0;
        low      = 0;
        gap_left = (xq.size() > 0) ? xq[0].gap : 0;
        while (xq.size() > 0 || have_dp) begin
            drive_addr = (xq.size() > 0) && (gap_left == 0);
            if (drive_addr) begin
                hsel_bus = 1'b1;
                htrans   = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                haddr    = xq[0].addr;
                hwrite   = xq[0].wr;
                hsize    = xq[0].size;
                hburst   = 3'($urandom);
                hprot    = 4'($urandom);
            end else begin
                idle_drive();
            end
            hwdata = have_dp ? dp.wdata : $urandom;
            @(negedge hclk);
            r_rdy  = o_rdy;
            r_resp = o_resp;
            r_rd   = o_rdata;
            if (have_dp) begin
                if (!r_rdy) begin
                    low++;
                    exp_err = mdl_err(cur, dp);
                    if (r_resp !== (exp_err ? 2'd1 : 2'd0) || r_rd !== 32'd0) bad_low = 1'b1;
                    if (low > 40) begin
                        check_eq("ready_timeout", 32'(low), 32'(ws_of(cur)));
                        xq.delete();
                        have_dp = 1'b0;
                    end
                end else begin
                    complete(dp, low, bad_low, r_resp, r_rd);
                end
            end else begin
                check_eq("idle_outputs", {r_rdy, r_resp, r_rd[28:0]}, 32'h8000_0000);
            end
            @(posedge hclk);
            #1;
            if (r_rdy) begin
                have_dp = 1'b0;
                if (drive_addr) begin
                    dp       = xq.pop_front();
                    have_dp  = 1'b1;
                    low      = 0;
                    bad_low  = 1'b0;
                    gap_left = (xq.size() > 0) ? xq[0].gap : 0;
                end else if (gap_left > 0) begin
                    gap_left--;
                end
            end
        end
        hsel_bus = 1'b0;
        htrans   = HTRANS_IDLE;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          r;
        idle_drive();
        hsel_bus = 1'b0;
        hwdata   = '0;
        last_rd  = '0;
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < DEPTH; w++) mdl[d][w] = '0;

        // Reset state
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            cur = d;
            #1;
            check_eq("rst_outputs", {o_rdy, o_resp, o_rdata[28:0]}, 32'h8000_0000);
            check_eq("rst_state", 32'(o_st), 32'(ST_IDLE));
        end
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;

        // Known memory contents
        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int w = 0; w < DEPTH; w++) push(1, 32'(w * 4), 3'd2, 32'd0, 0);
            run_seq();
        end

        // Back-to-back write/read, byte merge, error cases on u0
        cur = 0;
        push(1, 32'h10, 3'd2, 32'hDEADBEEF, 0);
        push(0, 32'h10, 3'd2, 32'h0, 0);
        run_seq();
        check_eq("b2b_read_value", last_rd, 32'hDEADBEEF);
        push(1, 32'h10, 3'd2, 32'h11223344, 0);
        push(1, 32'h13, 3'd0, 32'hAA000000, 0);
        push(0, 32'h10, 3'd2, 32'h0, 0);
        run_seq();
        check_eq("byte_merge_value", last_rd, 32'hAA223344);
        push(1, 32'h11, 3'd1, 32'hFFFFFFFF, 1);
        push(0, 32'h01, 3'd1, 32'h0, 0);
        push(0, 32'(DEPTH * 4), 3'd2, 32'h0, 0);
        push(1, 32'h10, 3'd3, 32'hFFFFFFFF, 0);
        push(0, 32'h10, 3'd2, 32'h0, 0);
        run_seq();
        check_eq("after_err_value", last_rd, 32'hAA223344);

        // Wait-state slave
        cur = 1;
        push(1, 32'h40, 3'd2, 32'hCAFEF00D, 0);
        push(0, 32'h40, 3'd2, 32'h0, 0);
        push(0, 32'h1000, 3'd2, 32'h0, 0);
        run_seq();
        check_eq("ws_read_value", last_rd, 32'hCAFEF00D);

        // Wrapping slave
        cur = 2;
        push(1, 32'h400, 3'd2, 32'h55, 0);
        push(0, 32'h000, 3'd2, 32'h0, 0);
        run_seq();
        check_eq("wrap_read_value", last_rd, 32'h55);

        // Random traffic on every slave
        for (int d = 0; d < 3; d++) begin
            cur = d;
            for (int n = 0; n < 120; n++) begin
                r  = $urandom_range(0, 9);
                sz = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'd3;
                a  = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 1023))
                                                : 32'($urandom_range(1024, 2047));
                if ($urandom_range(0, 9) < 8) a = a & ~(32'((1 << sz) - 1));
                push(1'($urandom), a, sz, $urandom,
                     ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2));
            end
            run_seq();
        end

        // Reset in the middle of a wait-stated write
        cur = 1;
        push(1, 32'h20, 3'd2, 32'h0, 0);
        run_seq();
        hsel_bus = 1'b1;
        htrans   = HTRANS_NONSEQ;
        haddr    = 32'h20;
        hwrite   = 1'b1;
        hsize    = 3'd2;
        @(posedge hclk);
        #1;
        hsel_bus = 1'b0;
        htrans   = HTRANS_IDLE;
        hwdata   = 32'h12345678;
        @(negedge hclk);
        check_eq("pre_rst_wait", {31'd0, o_rdy}, 32'd0);
        hresetn = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {o_rdy, o_resp, o_rdata[28:0]}, 32'h8000_0000);
        check_eq("mid_rst_rdata", o_rdata, 32'd0);
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        @(posedge hclk);
        #1;
        last_rd = 32'hFFFFFFFF;
        push(0, 32'h20, 3'd2, 32'h0, 0);
        run_seq();
        check_eq("rst_dropped_write", last_rd, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
